mul32_hs_resp: RTL and testbench
================================

MUL32_HS_RESP -- requirements
Module: mul32_hs_resp

Interface
REQ-001 SHALL have parameter KEY, default 19'h2A5C3: the correct unlock value for working_key.
REQ-002 SHALL have port ap_clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port ap_rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port ap_start, input, 1 bit: initiator requests an operation.
REQ-005 SHALL have port ap_done, output, 1 bit: one-cycle pulse; ap_return is valid.
REQ-006 SHALL have port ap_idle, output, 1 bit: the block is idle and no request is pending.
REQ-007 SHALL have port ap_ready, output, 1 bit: one-cycle pulse; operands have been consumed.
REQ-008 SHALL have port a, input, 64 bits: operand A (only a[31:0] is used).
REQ-009 SHALL have port b, input, 64 bits: operand B (only b[31:0] is used).
REQ-010 SHALL have port ap_return, output, 64 bits: result, registered.
REQ-011 SHALL have port working_key, input, 19 bits: locking key, sampled at operand capture.

Function
REQ-012 SHALL implement the responder (callee) side of the ap_start/ap_done/ap_idle/ap_ready block-level handshake.
REQ-013 SHALL use an FSM with one-hot states S_IDLE, S_CALC, S_DONE.
REQ-014 S_IDLE with ap_start=1 SHALL capture a[31:0], b[31:0] and working_key, clear the accumulator and the 6-bit counter, assert ap_ready combinationally in that same cycle, and go to S_CALC.
REQ-015 S_IDLE with ap_start=0 SHALL hold state, with ap_idle=1 and ap_ready=0.
REQ-016 S_CALC SHALL perform one radix-2 shift-add step per cycle for exactly 32 cycles:
- if the multiplier LSB=1, acc += multiplicand shifted left by count (64-bit, no overflow possible);
- multiplier shifts right by 1; count increments.
REQ-017 S_CALC SHALL go to S_DONE on the cycle in which count==31 completes; there SHALL be no early exit on a zero multiplier.
REQ-018 On entry to S_DONE, ap_return SHALL be loaded with acc ^ {45'b0, captured_key ^ KEY}; a wrong key therefore corrupts bits [18:0] only.
REQ-019 S_DONE SHALL assert ap_done=1 for exactly one cycle, then go to S_IDLE.
REQ-020 Latency SHALL be fixed: the start-accept cycle is T, and ap_done=1 occurs in cycle T+33.
REQ-021 ap_return SHALL hold its value from S_DONE until the next S_DONE; it SHALL NOT change during S_CALC.
REQ-022 ap_start held high continuously SHALL cause back-to-back operations; the next accept occurs in the S_IDLE cycle after S_DONE, one idle cycle between operations.
REQ-023 Changes on ap_start, a, b or working_key while in S_CALC or S_DONE SHALL be ignored.
REQ-024 ap_idle SHALL be 0 in S_CALC, in S_DONE, and in S_IDLE when ap_start=1.
REQ-025 ap_ready and ap_done SHALL never be asserted in the same cycle.
REQ-026 An illegal (non-one-hot) FSM state SHALL recover to S_IDLE on the next clock.

Reset
REQ-027 Asserting ap_rst low SHALL immediately force:
- the FSM to S_IDLE;
- ap_return, acc and counter to 0;
- ap_done=0 and ap_ready=0.
REQ-028 Reset asserted mid-operation SHALL abort the operation with no ap_done pulse; after release, the first ap_start begins a fresh operation.
REQ-029 After reset with ap_start=0, ap_idle SHALL be 1.

Verification
REQ-030 Bench SHALL check: a=3, b=5, working_key=KEY, 1-cycle start -> ap_ready at T, ap_done at T+33, ap_return=64'd15.
REQ-031 Bench SHALL check: a=b=32'hFFFFFFFF, correct key -> ap_return=64'hFFFFFFFE00000001.
REQ-032 Bench SHALL check: a=7, b=6, working_key=KEY^19'h1 -> ap_return=64'd43 (42^1).
REQ-033 Bench SHALL check: a=0, b=9 -> still 33-cycle latency, ap_return=0; with a upper bits=32'hDEAD, result is unaffected.
REQ-034 Bench SHALL check: ap_start held high for 3 operations -> ap_ready at T, T+34, T+68, and ap_done one cycle before each subsequent ap_ready.
REQ-035 Bench SHALL check: reset pulsed low at T+10 -> no ap_done; ap_return=0; ap_idle=1; a following operation 4*5 -> 20.

Source files
------------

// File: rtl/mul32_hs_resp.sv
// rtl/mul32_hs_resp.sv - 32x32 shift-add multiplier behind an ap_start/ap_done block handshake
//
// Ports:
//   ap_clk       clock, rising edge
//   ap_rst       asynchronous reset, active low
//   ap_start     initiator requests an operation
//   ap_done      one-cycle pulse, ap_return valid
//   ap_idle      idle with no pending request
//   ap_ready     one-cycle pulse, operands consumed
//   a, b         operands (only [31:0] used)
//   ap_return    registered 64-bit result
//   working_key  unlock key, sampled with the operands
module mul32_hs_resp #(
    parameter logic [18:0] KEY = 19'h2A5C3
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] ap_return,
    input  logic [18:0] working_key
);

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_CALC = 3'b010,
        S_DONE = 3'b100
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [63:0] acc;
    logic [63:0] addend;
    logic [63:0] acc_step;
    logic [5:0]  count;
    logic [18:0] key_q;
    logic        accept;
    logic        calc_last;

    // Upper operand halves are part of the interface but carry no meaning.
    logic unused_upper;
    assign unused_upper = ^{a[63:32], b[63:32]};

    // Qualified by ap_rst so ap_ready stays low while reset is held,
    // even if the initiator is already requesting.
    assign accept    = ap_rst && (state == S_IDLE) && ap_start;
    assign calc_last = (state == S_CALC) && (count == 6'd31);

    assign addend   = mplier[0] ? ({32'b0, mcand} << count) : 64'd0;
    assign acc_step = acc + addend;

    always_comb begin
        state_next = S_IDLE;
        ap_ready   = accept;
        ap_idle    = (state == S_IDLE) && !ap_start;
        ap_done    = (state == S_DONE);
        case (state)
            S_IDLE:  state_next = ap_start ? S_CALC : S_IDLE;
            S_CALC:  state_next = (count == 6'd31) ? S_DONE : S_CALC;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;   // non-one-hot encodings recover here
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst) begin
        if (!ap_rst) begin
            state     <= S_IDLE;
            acc       <= 64'd0;
            count     <= 6'd0;
            mcand     <= 32'd0;
            mplier    <= 32'd0;
            key_q     <= 19'd0;
            ap_return <= 64'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                mcand  <= a[31:0];
                mplier <= b[31:0];
                key_q  <= working_key;
                acc    <= 64'd0;
                count  <= 6'd0;
            end else if (state == S_CALC) begin
                acc    <= acc_step;
                mplier <= mplier >> 1;
                count  <= count + 6'd1;
            end
            // Load on the final step using acc_step so the last partial
            // product is included; a wrong key flips only bits [18:0].
            if (calc_last) begin
                ap_return <= acc_step ^ {45'b0, key_q ^ KEY};
            end
        end
    end

endmodule

// File: tb/tb_mul32_hs_resp.sv
// tb/tb_mul32_hs_resp.sv - scoreboard bench for mul32_hs_resp
module tb_mul32_hs_resp;

    localparam logic [18:0] KEY = 19'h2A5C3;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b0;
    logic        ap_start = 1'b0;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic [63:0] a = 64'd0;
    logic [63:0] b = 64'd0;
    logic [63:0] ap_return;
    logic [18:0] working_key = 19'd0;

    mul32_hs_resp #(.KEY(KEY)) dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .ap_start    (ap_start),
        .ap_done     (ap_done),
        .ap_idle     (ap_idle),
        .ap_ready    (ap_ready),
        .a           (a),
        .b           (b),
        .ap_return   (ap_return),
        .working_key (working_key)
    );

    always #5 ap_clk = ~ap_clk;

    int cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    int          ready_q[$];
    int          done_q[$];
    logic [63:0] ret_q[$];
    logic [63:0] exp_q[$];

    int tests = 0;
    int fails = 0;
    int overlap = 0;
    int glitch = 0;
    logic [63:0] prev_ret = 64'd0;

    always @(negedge ap_clk) begin
        if (ap_ready) ready_q.push_back(cyc);
        if (ap_done) begin
            done_q.push_back(cyc);
            ret_q.push_back(ap_return);
        end
        if (ap_ready && ap_done) overlap++;
        if (ap_rst && !ap_done && ap_return !== prev_ret) glitch++;
        prev_ret = ap_return;
    end

    task automatic tick;
        @(posedge ap_clk);
        #2;
    endtask

    task automatic clear_q;
        ready_q.delete();
        done_q.delete();
        ret_q.delete();
        exp_q.delete();
    endtask

    task automatic push_exp(input logic [63:0] av, input logic [63:0] bv, input logic [18:0] kv);
        logic [63:0] p;
        p = 64'(av[31:0]) * 64'(bv[31:0]);
        exp_q.push_back(p ^ {45'b0, kv ^ KEY});
    endtask

    // One-cycle start pulse, then scramble inputs to prove they are ignored.
    task automatic start_op(input logic [63:0] av, input logic [63:0] bv, input logic [18:0] kv,
                            input bit push, output int t0);
        tick;
        a = av; b = bv; working_key = kv; ap_start = 1'b1;
        t0 = cyc;
        if (push) push_exp(av, bv, kv);
        tick;
        ap_start = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        working_key = 19'($urandom);
    endtask

    task automatic run_op(input logic [63:0] av, input logic [63:0] bv, input logic [18:0] kv,
                          output int t0, output int r, output int d,
                          output logic [63:0] obs, output logic [63:0] expv, output bit to);
        int n;
        clear_q();
        start_op(av, bv, kv, 1'b1, t0);
        n = 0;
        while (done_q.size() == 0 && n < 60) begin
            tick;
            n++;
        end
        to = (done_q.size() == 0) || (ready_q.size() == 0);
        r = -1; d = -1; obs = 64'd0;
        if (!to) begin
            r   = ready_q.pop_front();
            d   = done_q.pop_front();
            obs = ret_q.pop_front();
        end
        expv = exp_q.pop_front();
    endtask

    task automatic test_reset;
        ap_rst = 1'b0;
        repeat (3) tick;
        ap_start = 1'b1;
        #1;
        tests++; if (ap_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", ap_ready); end
        tests++; if (ap_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", ap_done); end
        ap_start = 1'b0;
        #1;
        tests++; if (ap_return !== 64'd0) begin fails++; $display("FAIL reset_return: got %h want 0", ap_return); end
        tests++; if (ap_idle !== 1'b1) begin fails++; $display("FAIL reset_idle: got %b want 1", ap_idle); end
        tick;
        ap_rst = 1'b1;
        tick;
        tests++; if (ap_idle !== 1'b1) begin fails++; $display("FAIL post_reset_idle: got %b want 1", ap_idle); end
        tests++; if (ap_ready !== 1'b0) begin fails++; $display("FAIL post_reset_ready: got %b want 0", ap_ready); end
    endtask

    task automatic test_basic;
        int t0, r, d; logic [63:0] o, e; bit to;
        run_op(64'd3, 64'd5, KEY, t0, r, d, o, e, to);
        tests++;
        if (to) begin fails++; $display("FAIL basic_timeout: got none want ap_done"); end
        else begin
            tests++; if (r !== t0) begin fails++; $display("FAIL basic_ready_cycle: got %0d want %0d", r, t0); end
            tests++; if (d !== t0 + 33) begin fails++; $display("FAIL basic_done_cycle: got %0d want %0d", d, t0 + 33); end
            tests++; if (o !== e) begin fails++; $display("FAIL basic_sb: got %h want %h", o, e); end
            tests++; if (o !== 64'd15) begin fails++; $display("FAIL basic_15: got %0d want 15", o); end
        end
    endtask

    task automatic test_idle_in_calc;
        int t0;
        clear_q();
        start_op(64'd2, 64'd2, KEY, 1'b0, t0);
        ap_start = 1'b1;   // must be ignored mid-operation
        #1;
        tests++; if (ap_idle !== 1'b0) begin fails++; $display("FAIL calc_idle: got %b want 0", ap_idle); end
        tests++; if (ap_ready !== 1'b0) begin fails++; $display("FAIL calc_ready: got %b want 0", ap_ready); end
        ap_start = 1'b0;
        repeat (40) tick;
        tests++; if (done_q.size() != 1) begin fails++; $display("FAIL calc_done_count: got %0d want 1", done_q.size()); end
        tests++; if (ret_q.size() > 0 && ret_q[0] !== 64'd4) begin fails++; $display("FAIL calc_result: got %0d want 4", ret_q[0]); end
    endtask

    task automatic test_max;
        int t0, r, d; logic [63:0] o, e; bit to;
        run_op(64'hFFFFFFFF, 64'hFFFFFFFF, KEY, t0, r, d, o, e, to);
        tests++;
        if (to) begin fails++; $display("FAIL max_timeout: got none want ap_done"); end
        else begin
            tests++; if (o !== 64'hFFFFFFFE00000001) begin fails++; $display("FAIL max_result: got %h want fffffffe00000001", o); end
            tests++; if (o !== e) begin fails++; $display("FAIL max_sb: got %h want %h", o, e); end
        end
    endtask

    task automatic test_wrong_key;
        int t0, r, d; logic [63:0] o, e; bit to;
        run_op(64'd7, 64'd6, KEY ^ 19'h1, t0, r, d, o, e, to);
        tests++;
        if (to) begin fails++; $display("FAIL wrongkey_timeout: got none want ap_done"); end
        else begin
            tests++; if (o !== 64'd43) begin fails++; $display("FAIL wrongkey_result: got %0d want 43", o); end
            tests++; if (o !== e) begin fails++; $display("FAIL wrongkey_sb: got %h want %h", o, e); end
        end
        run_op(64'd1000, 64'd1000, KEY ^ 19'h7FFFF, t0, r, d, o, e, to);
        tests++;
        if (to) begin fails++; $display("FAIL wrongkey2_timeout: got none want ap_done"); end
        else if (o !== e) begin fails++; $display("FAIL wrongkey2_sb: got %h want %h", o, e); end
    endtask

    task automatic test_zero;
        int t0, r, d; logic [63:0] o, e; bit to;
        run_op(64'd0, 64'd9, KEY, t0, r, d, o, e, to);
        tests++;
        if (to) begin fails++; $display("FAIL zero_timeout: got none want ap_done"); end
        else begin
            tests++; if (d - r !== 33) begin fails++; $display("FAIL zero_latency: got %0d want 33", d - r); end
            tests++; if (o !== 64'd0) begin fails++; $display("FAIL zero_result: got %h want 0", o); end
        end
        run_op({32'hDEAD, 32'd0}, 64'd9, KEY, t0, r, d, o, e, to);
        tests++;
        if (to) begin fails++; $display("FAIL upper_timeout: got none want ap_done"); end
        else begin
            tests++; if (o !== 64'd0) begin fails++; $display("FAIL upper_result: got %h want 0", o); end
        end
        run_op({32'hDEAD, 32'd6}, {32'hBEEF, 32'd7}, KEY, t0, r, d, o, e, to);
        tests++;
        if (to) begin fails++; $display("FAIL upper2_timeout: got none want ap_done"); end
        else if (o !== e) begin fails++; $display("FAIL upper2_sb: got %h want %h", o, e); end
    endtask

    task automatic test_back_to_back;
        int t0, n;
        clear_q();
        tick;
        a = 64'd11; b = 64'd13; working_key = KEY; ap_start = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 3; i++) push_exp(64'd11, 64'd13, KEY);
        n = 0;
        while (ready_q.size() < 3 && n < 150) begin tick; n++; end
        ap_start = 1'b0;
        n = 0;
        while (done_q.size() < 3 && n < 60) begin tick; n++; end
        tests++;
        if (ready_q.size() != 3 || done_q.size() != 3) begin
            fails++;
            $display("FAIL b2b_counts: got ready=%0d done=%0d want 3 3", ready_q.size(), done_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++; if (ready_q[i] !== t0 + 34 * i) begin fails++; $display("FAIL b2b_ready%0d: got %0d want %0d", i, ready_q[i], t0 + 34 * i); end
                tests++; if (done_q[i] !== t0 + 34 * i + 33) begin fails++; $display("FAIL b2b_done%0d: got %0d want %0d", i, done_q[i], t0 + 34 * i + 33); end
                tests++; if (ret_q[i] !== exp_q[i]) begin fails++; $display("FAIL b2b_result%0d: got %h want %h", i, ret_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_reset_mid;
        int t0, r, d, n; logic [63:0] o, e; bit to;
        clear_q();
        start_op(64'd9, 64'd9, KEY, 1'b0, t0);
        n = 0;
        while (cyc < t0 + 10 && n < 20) begin tick; n++; end
        ap_rst = 1'b0;
        #1;
        tests++; if (ap_return !== 64'd0) begin fails++; $display("FAIL midrst_return: got %h want 0", ap_return); end
        tests++; if (ap_idle !== 1'b1) begin fails++; $display("FAIL midrst_idle: got %b want 1", ap_idle); end
        tick;
        ap_rst = 1'b1;
        repeat (45) tick;
        tests++; if (done_q.size() != 0) begin fails++; $display("FAIL midrst_no_done: got %0d want 0", done_q.size()); end
        tests++; if (ap_idle !== 1'b1) begin fails++; $display("FAIL midrst_idle_after: got %b want 1", ap_idle); end
        run_op(64'd4, 64'd5, KEY, t0, r, d, o, e, to);
        tests++;
        if (to) begin fails++; $display("FAIL midrst_op_timeout: got none want ap_done"); end
        else begin
            tests++; if (o !== 64'd20) begin fails++; $display("FAIL midrst_op_result: got %0d want 20", o); end
            tests++; if (d !== t0 + 33) begin fails++; $display("FAIL midrst_op_done: got %0d want %0d", d, t0 + 33); end
        end
    endtask

    task automatic test_invariants;
        tests++; if (overlap !== 0) begin fails++; $display("FAIL ready_done_overlap: got %0d want 0", overlap); end
        tests++; if (glitch !== 0) begin fails++; $display("FAIL return_stability: got %0d changes want 0", glitch); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_idle_in_calc();
        test_max();
        test_wrong_key();
        test_zero();
        test_back_to_back();
        test_reset_mid();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
